// File: rtl/cpu_pkg.sv
// ============================================================================
//  cpu_pkg
//  Shared types and constants for the CPU memory-side blocks.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int unsigned c_mem_lat_dflt = 2;
    localparam int unsigned c_aw_dflt      = 16;
    localparam int unsigned c_dw_dflt      = 16;

    // Requester identifiers held in the grant latch
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  mem_arbiter
//  Shares one memory port between instruction fetch and data access.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_LAT = c_mem_lat_dflt,
    parameter int unsigned AW      = c_aw_dflt,
    parameter int unsigned DW      = c_dw_dflt
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_re,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          hlt,
    output logic          stall
);

    localparam logic [3:0] c_cnt_last = 4'(MEM_LAT - 1);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          r_gnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_if_ok;
    logic          w_d_ok;
    logic          w_pick;
    logic          w_grant;
    logic          w_capture;
    logic          w_issue;
    logic          w_done;

    always_comb begin
        w_if_ok     = if_req & ~hlt;
        w_d_ok      = d_re | d_we;
        // Data wins unless it also won the previous grant and fetch is waiting
        w_pick      = (w_d_ok && !(w_if_ok && r_gnt == REQ_D)) ? REQ_D : REQ_IF;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_if_ok || w_d_ok) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_cnt == c_cnt_last) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_gnt      <= REQ_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant) begin
                r_gnt   <= w_pick;
                r_we    <= (w_pick == REQ_D) & d_we;
                r_addr  <= (w_pick == REQ_D) ? d_addr : if_addr;
                r_wdata <= d_wdata;
            end
            if (w_capture && !r_we) begin
                if (r_gnt == REQ_D) begin
                    r_d_rdata <= mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    // Outputs are forced quiet while reset is held, independent of state
    assign w_issue   = (r_state == ISSUE) & ~rst;
    assign w_done    = (r_state == DONE) & ~rst;

    assign mem_en    = w_issue;
    assign mem_we    = w_issue & r_we;
    assign mem_addr  = w_issue ? r_addr : '0;
    assign mem_wdata = w_issue ? r_wdata : '0;

    assign if_ack    = w_done & (r_gnt == REQ_IF);
    assign d_ack     = w_done & (r_gnt == REQ_D);
    assign if_rdata  = rst ? '0 : r_if_rdata;
    assign d_rdata   = rst ? '0 : r_d_rdata;

    assign stall     = (if_req & ~if_ack & ~hlt) | ((d_re | d_we) & ~d_ack);

endmodule

`default_nettype wire
